// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit write engine: runs the power-on init, then strobes each accepted byte as two nibbles.
// Ready is registered and drops for the whole strobe+exec time; DinValid while busy is ignored, never queued.
module lcd_nibble_writer #(
   parameter int T_SETUP      = 2,
   parameter int T_EPULSE     = 25,
   parameter int T_NIBBLE_GAP = 100,
   parameter int T_EXEC       = 4000,
   parameter int T_EXEC_LONG  = 164000,
   parameter int T_POWERUP    = 1500000,
   parameter int T_INIT1      = 410000,
   parameter int T_INIT2      = 10000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Din,
   input  logic       DinRS,
   input  logic       DinValid,
   output logic       Ready,
   output logic       InitDone,
   output logic [3:0] LCD_Data,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // All parameters must be >= 1; a zero load would wrap the down-counter.
   localparam int MAXV = max2(max2(T_POWERUP, T_EXEC_LONG), max2(T_INIT1, T_INIT2));
   localparam int CW   = $clog2(MAXV + 1);

   typedef enum logic [2:0] {
      S_INIT_WAIT, S_INIT_NIB, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_EXEC
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [1:0]      r_step, w_step_nxt;
   logic            r_phase, w_phase_nxt;
   logic [7:0]      r_din, w_din_nxt;
   logic            r_rs, w_rs_nxt;
   logic            r_init_done, w_init_done_nxt;
   logic            r_ready;
   logic            r_lcd_e;
   logic            r_lcd_rs, w_lcd_rs_nxt;
   logic [3:0]      r_lcd_data, w_lcd_data_nxt;
   logic            w_expired;
   logic            w_long;

   assign w_expired = (r_cnt == CW'(1));
   assign w_long    = ~r_rs && (r_din[7:2] == 6'd0) && (r_din[1:0] != 2'd0);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = (r_state == S_IDLE) ? r_cnt : r_cnt - CW'(1);
      w_step_nxt      = r_step;
      w_phase_nxt     = r_phase;
      w_din_nxt       = r_din;
      w_rs_nxt        = r_rs;
      w_init_done_nxt = r_init_done;
      w_lcd_rs_nxt    = r_lcd_rs;
      w_lcd_data_nxt  = r_lcd_data;
      case (r_state)
         S_INIT_WAIT: if (w_expired) begin
            w_state_nxt    = S_SETUP;
            w_cnt_nxt      = CW'(T_SETUP);
            w_step_nxt     = 2'd0;
            w_lcd_data_nxt = 4'h3;
            w_lcd_rs_nxt   = 1'b0;
         end
         S_SETUP: if (w_expired) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = CW'(T_EPULSE);
         end
         S_PULSE: if (w_expired) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = CW'(T_SETUP);
         end
         S_HOLD: if (w_expired) begin
            if (!r_init_done) begin
               w_state_nxt = S_INIT_NIB;
               case (r_step)
                  2'd0:    w_cnt_nxt = CW'(T_INIT1);
                  2'd1:    w_cnt_nxt = CW'(T_INIT2);
                  default: w_cnt_nxt = CW'(T_EXEC);
               endcase
            end else if (!r_phase) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = CW'(T_NIBBLE_GAP);
            end else begin
               w_state_nxt = S_EXEC;
               w_cnt_nxt   = w_long ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
            end
         end
         S_GAP: if (w_expired) begin
            w_state_nxt    = S_SETUP;
            w_cnt_nxt      = CW'(T_SETUP);
            w_phase_nxt    = 1'b1;
            w_lcd_data_nxt = r_din[3:0];
         end
         S_EXEC: if (w_expired) w_state_nxt = S_IDLE;
         S_INIT_NIB: if (w_expired) begin
            if (r_step == 2'd3) begin
               w_state_nxt     = S_IDLE;
               w_init_done_nxt = 1'b1;
            end else begin
               // Steps 0..2 are followed by 0x3,0x3,0x2 respectively.
               w_state_nxt    = S_SETUP;
               w_cnt_nxt      = CW'(T_SETUP);
               w_step_nxt     = r_step + 2'd1;
               w_lcd_data_nxt = (r_step == 2'd2) ? 4'h2 : 4'h3;
            end
         end
         S_IDLE: if (r_ready && DinValid) begin
            w_state_nxt    = S_SETUP;
            w_cnt_nxt      = CW'(T_SETUP);
            w_phase_nxt    = 1'b0;
            w_din_nxt      = Din;
            w_rs_nxt       = DinRS;
            w_lcd_data_nxt = Din[7:4];
            w_lcd_rs_nxt   = DinRS;
         end
         default: w_state_nxt = S_INIT_WAIT;
      endcase
   end

   // E and Ready are registered copies of the next state, so they track the state exactly.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state     <= S_INIT_WAIT;
         r_cnt       <= CW'(T_POWERUP);
         r_step      <= 2'd0;
         r_phase     <= 1'b0;
         r_din       <= 8'd0;
         r_rs        <= 1'b0;
         r_init_done <= 1'b0;
         r_ready     <= 1'b0;
         r_lcd_e     <= 1'b0;
         r_lcd_rs    <= 1'b0;
         r_lcd_data  <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_step      <= w_step_nxt;
         r_phase     <= w_phase_nxt;
         r_din       <= w_din_nxt;
         r_rs        <= w_rs_nxt;
         r_init_done <= w_init_done_nxt;
         r_ready     <= (w_state_nxt == S_IDLE) && w_init_done_nxt;
         r_lcd_e     <= (w_state_nxt == S_PULSE);
         r_lcd_rs    <= w_lcd_rs_nxt;
         r_lcd_data  <= w_lcd_data_nxt;
      end
   end

   assign Ready    = r_ready;
   assign InitDone = r_init_done;
   assign LCD_Data = r_lcd_data;
   assign LCD_E    = r_lcd_e;
   assign LCD_RS   = r_lcd_rs;
   assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with short sim timing parameters.
module tb_lcd_nibble_writer;

   localparam int TS = 2, TE = 4, TG = 3, TX = 5, TXL = 20, TP = 10, TI1 = 8, TI2 = 6;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [7:0] Din = 8'd0;
   logic       DinRS = 1'b0;
   logic       DinValid = 1'b0;
   logic       Ready, InitDone, LCD_E, LCD_RS, LCD_RW;
   logic [3:0] LCD_Data;

   lcd_nibble_writer #(
      .T_SETUP(TS), .T_EPULSE(TE), .T_NIBBLE_GAP(TG), .T_EXEC(TX),
      .T_EXEC_LONG(TXL), .T_POWERUP(TP), .T_INIT1(TI1), .T_INIT2(TI2)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Din(Din), .DinRS(DinRS), .DinValid(DinValid),
      .Ready(Ready), .InitDone(InitDone), .LCD_Data(LCD_Data),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0] d;
      logic       rs;
      int         w;
      int         t;
   } pulse_t;
   pulse_t pq[$];

   // E-pulse monitor: records every complete pulse and checks setup/hold framing.
   logic [3:0] m_last_d = 4'd0;
   logic       m_last_rs = 1'b0;
   bit         m_in = 1'b0;
   int         m_start = 0, m_chg = 0, m_fall = -100;
   pulse_t     m_p;
   always @(negedge Clk) begin
      if (!Rst) begin
         m_in = 1'b0;
      end else begin
         if (LCD_Data !== m_last_d || LCD_RS !== m_last_rs) begin
            if (m_in || (cyc - m_fall) < TS) begin
               bad++;
               $display("FAIL data_stable: data/rs changed at cycle %0d (fall %0d)", cyc, m_fall);
            end
            m_chg = cyc;
         end
         if (LCD_E && !m_in) begin
            m_in = 1'b1;
            m_start = cyc;
            total++;
            if (cyc - m_chg < TS) begin
               bad++;
               $display("FAIL setup_time: got %0d expected >= %0d", cyc - m_chg, TS);
            end
         end else if (!LCD_E && m_in) begin
            m_in = 1'b0;
            m_fall = cyc;
            m_p.d = m_last_d; m_p.rs = m_last_rs; m_p.w = cyc - m_start; m_p.t = m_start;
            pq.push_back(m_p);
         end
      end
      m_last_d  = LCD_Data;
      m_last_rs = LCD_RS;
   end

   always @(negedge Clk) begin
      total++;
      assert (LCD_RW === 1'b0 && !(LCD_E === 1'b1 && Ready === 1'b1))
      else begin
         bad++;
         $display("FAIL rw_e_check: rw=%b e=%b ready=%b", LCD_RW, LCD_E, Ready);
      end
   end

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (Ready !== 1'b1 && n < 500) begin
         @(negedge Clk);
         n++;
      end
      ok = (Ready === 1'b1);
   endtask

   // Called just after the accepting edge; counts busy cycles until Ready returns.
   task automatic count_busy(output int d);
      d = 0;
      @(negedge Clk);
      while (Ready !== 1'b1 && d < 1000) begin
         d++;
         @(negedge Clk);
      end
   endtask

   task automatic send(input logic [7:0] din, input logic rs, input bit hold,
                       input logic [7:0] adin, input logic ars, output int d);
      bit ok;
      wait_ready(ok);
      chk("ready_before_send", int'(ok), 1);
      Din = din; DinRS = rs; DinValid = 1'b1;
      @(posedge Clk);
      #1;
      if (!hold) DinValid = 1'b0;
      Din = adin; DinRS = ars;
      count_busy(d);
   endtask

   task automatic chk_pulse(input string name, input logic [3:0] d, input logic rs);
      pulse_t p;
      p = pq.pop_front();
      chk({name, "_data"}, int'(p.d), int'(d));
      chk({name, "_rs"}, int'(p.rs), int'(rs));
      chk({name, "_width"}, p.w, TE);
   endtask

   task automatic release_and_check_init(input string name);
      int c, n;
      int exp_t[4];
      logic [3:0] exp_d[4];
      exp_t[0] = 12; exp_t[1] = 28; exp_t[2] = 42; exp_t[3] = 55;
      exp_d[0] = 4'h3; exp_d[1] = 4'h3; exp_d[2] = 4'h3; exp_d[3] = 4'h2;
      pq.delete();
      @(negedge Clk);
      Rst = 1'b1;
      c = cyc;
      n = 0;
      while (InitDone !== 1'b1 && n < 500) begin
         @(negedge Clk);
         n++;
      end
      chk({name, "_initdone_cycle"}, cyc - c, 66);
      chk({name, "_ready_after_init"}, int'(Ready), 1);
      chk({name, "_init_pulse_count"}, pq.size(), 4);
      if (pq.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_init%0d_rise", name, i), pq[0].t - c, exp_t[i]);
            chk_pulse($sformatf("%s_init%0d", name, i), exp_d[i], 1'b0);
         end
      end
   endtask

   typedef struct {
      logic [7:0] din;
      logic       rs;
      logic [3:0] hi;
      logic [3:0] lo;
      int         d;
   } vec_t;

   initial begin
      vec_t vecs[8];
      int d, n0, t_hi;
      bit ok;
      vecs[0] = '{8'h41, 1'b1, 4'h4, 4'h1, 24};
      vecs[1] = '{8'h01, 1'b0, 4'h0, 4'h1, 39};
      vecs[2] = '{8'h28, 1'b0, 4'h2, 4'h8, 24};
      vecs[3] = '{8'h00, 1'b0, 4'h0, 4'h0, 24};
      vecs[4] = '{8'h03, 1'b0, 4'h0, 4'h3, 39};
      vecs[5] = '{8'h04, 1'b0, 4'h0, 4'h4, 24};
      vecs[6] = '{8'h02, 1'b1, 4'h0, 4'h2, 24};
      vecs[7] = '{8'hFF, 1'b1, 4'hF, 4'hF, 24};

      repeat (3) @(negedge Clk);
      chk("rst_ready", int'(Ready), 0);
      chk("rst_initdone", int'(InitDone), 0);
      chk("rst_e", int'(LCD_E), 0);
      chk("rst_rs", int'(LCD_RS), 0);
      chk("rst_data", int'(LCD_Data), 0);

      release_and_check_init("boot");

      for (int i = 0; i < 8; i++) begin
         n0 = pq.size();
         send(vecs[i].din, vecs[i].rs, 1'b0, ~vecs[i].din, ~vecs[i].rs, d);
         chk($sformatf("v%0d_busy", i), d, vecs[i].d);
         chk($sformatf("v%0d_pulses", i), pq.size() - n0, 2);
         if (pq.size() == 2) begin
            chk($sformatf("v%0d_nibble_spacing", i), pq[1].t - pq[0].t, TE + 2 * TS + TG);
            chk_pulse($sformatf("v%0d_hi", i), vecs[i].hi, vecs[i].rs);
            chk_pulse($sformatf("v%0d_lo", i), vecs[i].lo, vecs[i].rs);
         end
         pq.delete();
      end

      // DinValid held through busy with a different byte: accepted on first Ready cycle.
      send(8'h41, 1'b1, 1'b1, 8'h5A, 1'b0, d);
      chk("hold_first_busy", d, 24);
      chk("hold_ready_seen", int'(Ready), 1);
      @(posedge Clk);
      #1;
      DinValid = 1'b0;
      Din = 8'h33; DinRS = 1'b1;
      count_busy(d);
      chk("hold_second_busy", d, 24);
      chk("hold_pulses", pq.size(), 4);
      if (pq.size() == 4) begin
         chk_pulse("hold_b0_hi", 4'h4, 1'b1);
         chk_pulse("hold_b0_lo", 4'h1, 1'b1);
         chk_pulse("hold_b1_hi", 4'h5, 1'b0);
         chk_pulse("hold_b1_lo", 4'hA, 1'b0);
      end
      pq.delete();

      // Reset while E is high on the low nibble.
      wait_ready(ok);
      Din = 8'h7E; DinRS = 1'b1; DinValid = 1'b1;
      @(posedge Clk);
      #1;
      DinValid = 1'b0;
      t_hi = 0;
      @(negedge Clk);
      while (!(pq.size() == 1 && LCD_E === 1'b1) && t_hi < 100) begin
         @(negedge Clk);
         t_hi++;
      end
      chk("abort_reached_low_pulse", int'(pq.size() == 1 && LCD_E === 1'b1), 1);
      #2;
      Rst = 1'b0;
      #1;
      chk("abort_e_async", int'(LCD_E), 0);
      chk("abort_ready_async", int'(Ready), 0);
      chk("abort_initdone_async", int'(InitDone), 0);
      chk("abort_data_async", int'(LCD_Data), 0);
      chk("abort_rs_async", int'(LCD_RS), 0);
      repeat (4) @(negedge Clk);
      release_and_check_init("reinit");
      chk("reinit_no_extra_pulse", pq.size(), 0);

      send(8'h41, 1'b1, 1'b0, 8'h00, 1'b0, d);
      chk("post_reinit_busy", d, 24);
      chk("post_reinit_pulses", pq.size(), 2);
      if (pq.size() == 2) begin
         chk_pulse("post_reinit_hi", 4'h4, 1'b1);
         chk_pulse("post_reinit_lo", 4'h1, 1'b1);
      end
      repeat (10) @(negedge Clk);
      chk("idle_no_pulse", pq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
